// File: rtl/torus_mult_pipe.sv
// torus_mult_pipe: pipelined signed multiplier with per-beat LO/HI/MAC modes and valid/ready flow control
module torus_mult_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [1:0]            mode,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out
);
  localparam int W = DATA_WIDTH;
  localparam int D = STAGES - 1;
  localparam logic [1:0] M_HI = 2'b01;
  localparam logic [1:0] M_MAC = 2'b10;
  logic [2*W-1:0] r_p [D];
  logic [1:0]     r_m [D];
  logic           r_l [D];
  logic           r_v [D];
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_out;
  logic           r_ov;
  logic           w_adv;
  logic           w_mac;
  logic           w_emit;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_lo;
  logic [W-1:0]   w_hi;
  logic [W-1:0]   w_sum;
  logic [W-1:0]   w_res;
  assign w_adv     = !r_ov || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_ov;
  assign out       = r_out;
  // both operands sign-extended to 2W, so the low 2W bits of the unsigned product are the signed product
  assign w_prod = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
  assign w_lo   = r_p[D-1][W-1:0];
  assign w_hi   = r_p[D-1][2*W-1:W];
  assign w_mac  = r_m[D-1] == M_MAC;
  assign w_sum  = r_acc + w_lo;
  assign w_emit = r_v[D-1] && (!w_mac || r_l[D-1]);
  assign w_res  = w_mac ? w_sum : (r_m[D-1] == M_HI ? w_hi : w_lo);
  // product pipeline: each beat carries its product, mode, last flag and valid bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < D; i++) begin
        r_p[i] <= '0;
        r_m[i] <= '0;
        r_l[i] <= 1'b0;
        r_v[i] <= 1'b0;
      end
    end else if (w_adv) begin
      r_p[0] <= w_prod;
      r_m[0] <= mode;
      r_l[0] <= in_last;
      r_v[0] <= in_valid;
      for (int i = 1; i < D; i++) begin
        r_p[i] <= r_p[i-1];
        r_m[i] <= r_m[i-1];
        r_l[i] <= r_l[i-1];
        r_v[i] <= r_v[i-1];
      end
    end
  // output register and accumulator; non-last MAC beats only fold into acc
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_ov  <= 1'b0;
      r_out <= '0;
      r_acc <= '0;
    end else if (w_adv) begin
      r_ov <= w_emit;
      if (w_emit) r_out <= w_res;
      if (r_v[D-1] && w_mac) r_acc <= r_l[D-1] ? '0 : w_sum;
    end
endmodule
